// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage GPR file for the 5-stage MIPS pipeline.
// Selects the writeback value and commits it on the clock edge. Provides two
// combinational read ports with a same-cycle write bypass, and keeps a
// retired-write counter for debug.
// r0 is hardwired to zero on writes, reads and the bypass path.
module wb_regfile #(
  parameter int DATA_W     = 32,
  parameter int NREGS_LOG2 = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_regwrite,
  input  logic                  wb_memtoreg,
  input  logic [DATA_W-1:0]     wb_readdata,
  input  logic [DATA_W-1:0]     wb_aluresult,
  input  logic [NREGS_LOG2-1:0] wb_writereg,
  input  logic [NREGS_LOG2-1:0] rs_addr,
  input  logic [NREGS_LOG2-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_commit,
  output logic [CNT_W-1:0]      retired_cnt
);

  localparam int NREGS = 1 << NREGS_LOG2;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_wb_data;
  logic              w_commit;
  logic              w_rs_bypass;
  logic              w_rt_bypass;

  assign w_wb_data = wb_memtoreg ? wb_readdata : wb_aluresult;

  // Writes to r0 and writes during reset never take effect, so they are
  // never committed, bypassed or counted.
  assign w_commit = wb_regwrite && (wb_writereg != '0) && !reset;

  assign w_rs_bypass = w_commit && (rs_addr == wb_writereg);
  assign w_rt_bypass = w_commit && (rt_addr == wb_writereg);

  // Register array and retired counter: clear on reset, else commit one write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_cnt <= '0;
    end else if (w_commit) begin
      r_regs[wb_writereg] <= w_wb_data;
      r_cnt               <= r_cnt + CNT_W'(1);
    end
  end

  // Read ports: r0 reads zero; otherwise bypass the in-flight write or read the array.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) begin
      rs_data = w_rs_bypass ? w_wb_data : r_regs[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_data = w_rt_bypass ? w_wb_data : r_regs[rt_addr];
    end
  end

  assign wb_data     = w_wb_data;
  assign wb_commit   = w_commit;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile. The counter is built 4 bits wide so that
// wrap-around can be reached with a short write sequence.
module tb_wb_regfile;

  localparam int DATA_W     = 32;
  localparam int NREGS_LOG2 = 5;
  localparam int CNT_W      = 4;

  logic                  clk;
  logic                  reset;
  logic                  wb_regwrite;
  logic                  wb_memtoreg;
  logic [DATA_W-1:0]     wb_readdata;
  logic [DATA_W-1:0]     wb_aluresult;
  logic [NREGS_LOG2-1:0] wb_writereg;
  logic [NREGS_LOG2-1:0] rs_addr;
  logic [NREGS_LOG2-1:0] rt_addr;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_commit;
  logic [CNT_W-1:0]      retired_cnt;

  int n_chk = 0;
  int n_bad = 0;

  wb_regfile #(
    .DATA_W     (DATA_W),
    .NREGS_LOG2 (NREGS_LOG2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_regwrite  (wb_regwrite),
    .wb_memtoreg  (wb_memtoreg),
    .wb_readdata  (wb_readdata),
    .wb_aluresult (wb_aluresult),
    .wb_writereg  (wb_writereg),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_data      (wb_data),
    .wb_commit    (wb_commit),
    .retired_cnt  (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    wb_regwrite  = 1'b1;
    wb_memtoreg  = 1'b0;
    wb_aluresult = val;
    wb_writereg  = idx;
    step();
    wb_regwrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_regwrite = 1'b0; wb_memtoreg = 1'b0;
    wb_readdata = '0; wb_aluresult = '0; wb_writereg = '0;
    rs_addr = '0; rt_addr = '0;
    #1;
    step();
    // commit suppressed while reset is high
    wb_regwrite = 1'b1; wb_writereg = 5'd4; wb_aluresult = 32'h44;
    #1;
    chk("commit_in_reset", {31'b0, wb_commit}, 32'd0);
    step();
    wb_regwrite = 1'b0; reset = 1'b0; rs_addr = 5'd4;
    #1;
    chk("reset_r4", rs_data, 32'd0);
    chk("reset_cnt", {28'b0, retired_cnt}, 32'd0);

    // reset clear
    wr(5'd5, 32'hDEADBEEF);
    rs_addr = 5'd5; #1;
    chk("r5_written", rs_data, 32'hDEADBEEF);
    chk("cnt_1", {28'b0, retired_cnt}, 32'd1);
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("r5_cleared", rs_data, 32'd0);
    chk("cnt_cleared", {28'b0, retired_cnt}, 32'd0);

    // mux and commit
    wb_regwrite = 1'b1; wb_memtoreg = 1'b1;
    wb_readdata = 32'h11111111; wb_aluresult = 32'h22222222; wb_writereg = 5'd8;
    #1;
    chk("wbdata_load", wb_data, 32'h11111111);
    chk("commit_r8", {31'b0, wb_commit}, 32'd1);
    step();
    wb_memtoreg = 1'b0; wb_writereg = 5'd9; #1;
    chk("wbdata_alu", wb_data, 32'h22222222);
    step();
    wb_regwrite = 1'b0; rs_addr = 5'd8; rt_addr = 5'd9; #1;
    chk("r8", rs_data, 32'h11111111);
    chk("r9", rt_data, 32'h22222222);
    chk("cnt_2", {28'b0, retired_cnt}, 32'd2);
    chk("wbdata_noregwrite", wb_data, 32'h22222222);

    // bypass
    wr(5'd3, 32'h5);
    rs_addr = 5'd3; rt_addr = 5'd3; #1;
    chk("r3_old", rs_data, 32'h5);
    wb_regwrite = 1'b1; wb_writereg = 5'd3; wb_aluresult = 32'hABCD0123; #1;
    chk("bypass_rs", rs_data, 32'hABCD0123);
    chk("bypass_rt", rt_data, 32'hABCD0123);
    step();
    wb_regwrite = 1'b0; #1;
    chk("r3_after", rs_data, 32'hABCD0123);
    chk("cnt_4", {28'b0, retired_cnt}, 32'd4);

    // r0 protection
    wb_regwrite = 1'b1; wb_writereg = 5'd0; wb_aluresult = 32'hFFFFFFFF;
    rs_addr = 5'd0; rt_addr = 5'd0; #1;
    chk("r0_same_cycle", rs_data, 32'd0);
    chk("r0_commit", {31'b0, wb_commit}, 32'd0);
    step();
    wb_regwrite = 1'b0; #1;
    chk("r0_after", rt_data, 32'd0);
    chk("cnt_r0", {28'b0, retired_cnt}, 32'd4);

    // disabled write
    wr(5'd7, 32'h77);
    wb_regwrite = 1'b0; wb_writereg = 5'd7; wb_aluresult = 32'h1234; rs_addr = 5'd7; #1;
    chk("r7_no_bypass", rs_data, 32'h77);
    chk("r7_commit", {31'b0, wb_commit}, 32'd0);
    step();
    chk("r7_unchanged", rs_data, 32'h77);
    chk("cnt_5", {28'b0, retired_cnt}, 32'd5);

    // counter wrap: 17 writes to r1 on a 4-bit counter
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr(5'd1, 32'd100 + 32'(i));
    end
    rs_addr = 5'd1; #1;
    chk("r1_last", rs_data, 32'd116);
    chk("cnt_wrap", {28'b0, retired_cnt}, 32'd1);

    // reset colliding with a write to r2
    reset = 1'b1; wb_regwrite = 1'b1; wb_writereg = 5'd2; wb_aluresult = 32'h2222;
    rt_addr = 5'd2; #1;
    chk("rst_no_bypass", rt_data, 32'd0);
    chk("rst_r1_held", rs_data, 32'd116);
    step();
    reset = 1'b0; wb_regwrite = 1'b0; #1;
    chk("rst_r2", rt_data, 32'd0);
    chk("rst_r1", rs_data, 32'd0);
    chk("rst_cnt", {28'b0, retired_cnt}, 32'd0);

    // first write after reset commits normally
    wr(5'd2, 32'h55);
    #1;
    chk("post_rst_r2", rt_data, 32'h55);
    chk("post_rst_cnt", {28'b0, retired_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
